// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single-port memory slave: data-side priority with
// a fetch starvation guard, plus an owner-tag FIFO that steers in-order responses back.
module mem_bus_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_STREAK  = 4,
    parameter int OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            s_req,
    output logic            s_we,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic            s_gnt,
    input  logic            s_rvalid,
    input  logic [DW-1:0]   s_rdata,
    output logic            busy,
    output logic            err
);

    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(OUTSTANDING);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    logic [CW-1:0]          count;
    logic [SW-1:0]          streak;
    logic [OUTSTANDING-1:0] tags;
    logic [OUTSTANDING-1:0] tags_shift;
    logic [OUTSTANDING-1:0] tags_nxt;
    logic [CW-1:0]          wr_idx;
    logic                   sel_m1;
    logic                   has_entry;
    logic                   accept;
    logic                   pop;

    function automatic logic [SW-1:0] streak_sat_inc(input logic [SW-1:0] cur);
        return (cur == STREAK_MAX) ? cur : cur + SW'(1);
    endfunction

    // Selection and request path: combinational, gated off while reset is held
    assign sel_m1    = m1_req && !(m0_req && (streak == STREAK_MAX));
    assign has_entry = (count != '0);
    assign s_req     = rst && (m0_req || m1_req) && (count < CNT_MAX);
    assign accept    = s_req && s_gnt;
    assign m0_gnt    = accept && !sel_m1;
    assign m1_gnt    = accept && sel_m1;

    assign s_addr  = sel_m1 ? m1_addr : m0_addr;
    assign s_we    = sel_m1 && m1_we;
    assign s_wdata = sel_m1 ? m1_wdata : '0;
    assign s_wstrb = sel_m1 ? m1_wstrb : '0;

    assign pop       = s_rvalid && has_entry;
    assign m0_rvalid = pop && !tags[0];
    assign m1_rvalid = pop && tags[0];
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign busy      = has_entry;

    // Owner FIFO kept head-at-bit-0: a pop shifts down, a push lands just past the tail
    always_comb begin
        wr_idx     = pop ? (count - CW'(1)) : count;
        tags_shift = tags;
        for (int i = 0; i < OUTSTANDING - 1; i++) begin
            tags_shift[i] = tags[i+1];
        end
        tags_nxt = pop ? tags_shift : tags;
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (accept && (wr_idx == CW'(i))) begin
                tags_nxt[i] = sel_m1;
            end
        end
    end

    always_ff @(posedge clk) begin
        tags <= tags_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            streak <= '0;
            err    <= 1'b0;
        end else begin
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (accept) begin
                streak <= (sel_m1 && m0_req) ? streak_sat_inc(streak) : '0;
            end
            if (s_rvalid && !has_entry) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized run
// against a queue-based owner/streak reference model.
module tb_mem_bus_arbiter;

    localparam int AW          = 32;
    localparam int DW          = 32;
    localparam int MAX_STREAK  = 4;
    localparam int OUTSTANDING = 2;

    logic            clk;
    logic            rst;
    logic            m0_req;
    logic [AW-1:0]   m0_addr;
    logic            m0_gnt;
    logic            m0_rvalid;
    logic [DW-1:0]   m0_rdata;
    logic            m1_req;
    logic            m1_we;
    logic [AW-1:0]   m1_addr;
    logic [DW-1:0]   m1_wdata;
    logic [DW/8-1:0] m1_wstrb;
    logic            m1_gnt;
    logic            m1_rvalid;
    logic [DW-1:0]   m1_rdata;
    logic            s_req;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_gnt;
    logic            s_rvalid;
    logic [DW-1:0]   s_rdata;
    logic            busy;
    logic            err;

    int checks = 0;
    int errors = 0;

    // Reference model: owners of in-flight transfers, oldest first, and the m1 streak
    int q[$];
    int mstreak;

    mem_bus_arbiter #(
        .AW(AW), .DW(DW), .MAX_STREAK(MAX_STREAK), .OUTSTANDING(OUTSTANDING)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        m0_req = 0; m0_addr = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_gnt = 0; s_rvalid = 0; s_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        q.delete();
        mstreak = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 0; m0_req = 1; m1_req = 1; s_gnt = 1;
        #1;
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_s_req: got %b exp 0", s_req); end
        checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_m0_gnt: got %b exp 0", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_m1_gnt: got %b exp 0", m1_gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        s_rvalid = 1;
        #1;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b exp 00", {m0_rvalid, m1_rvalid}); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
        idle_inputs();
        rst = 1;
        #1;
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_release: got busy=%b err=%b exp 0 0", busy, err); end
        q.delete();
        mstreak = 0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        m0_req = 1; m0_addr = 32'h80; s_gnt = 1;
        #1;
        checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt: got m0=%b m1=%b exp 1 0", m0_gnt, m1_gnt); end
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h80 || s_we !== 1'b0) begin errors++; $display("FAIL fetch_sreq: got req=%b addr=%h we=%b exp 1 80 0", s_req, s_addr, s_we); end
        @(negedge clk);
        m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h00000513;
        #1;
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h00000513) begin errors++; $display("FAIL fetch_rvalid: got %b %h exp 1 00000513", m0_rvalid, m0_rdata); end
        checks++; if (m1_rvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fetch_m1rv_busy: got %b %b exp 0 1", m1_rvalid, busy); end
        @(negedge clk);
        s_rvalid = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_busy_end: got %b exp 0", busy); end
    endtask

    task automatic test_contention();
        bit exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h200; s_gnt = 1;
        for (int k = 0; k < 10; k++) begin
            s_rvalid = (k > 0);
            #1;
            checks++; if (m1_gnt !== exp_seq[k] || m0_gnt !== !exp_seq[k]) begin errors++; $display("FAIL contention_gnt[%0d]: got m0=%b m1=%b exp m1=%b", k, m0_gnt, m1_gnt, exp_seq[k]); end
            if (k > 0) begin
                checks++; if (m1_rvalid !== exp_seq[k-1] || m0_rvalid !== !exp_seq[k-1]) begin errors++; $display("FAIL contention_rv[%0d]: got m0=%b m1=%b exp m1=%b", k, m0_rvalid, m1_rvalid, exp_seq[k-1]); end
            end
            @(negedge clk);
        end
        m0_req = 0; m1_req = 0; s_rvalid = 1;
        #1;
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL contention_last_rv: got %b exp 1", m0_rvalid); end
        @(negedge clk);
        s_rvalid = 0; s_gnt = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL contention_busy: got %b exp 0", busy); end
    endtask

    task automatic test_full();
        do_reset();
        m1_req = 1; m1_addr = 32'h300; s_gnt = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL full_fill[%0d]: got %b exp 1", k, m1_gnt); end
            @(negedge clk);
        end
        #1;
        checks++; if (s_req !== 1'b0 || m1_gnt !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_block: got req=%b gnt=%b busy=%b exp 0 0 1", s_req, m1_gnt, busy); end
        @(negedge clk);
        s_rvalid = 1;
        #1;
        checks++; if (s_req !== 1'b0 || m1_gnt !== 1'b0 || m1_rvalid !== 1'b1) begin errors++; $display("FAIL full_pop_cycle: got req=%b gnt=%b rv=%b exp 0 0 1", s_req, m1_gnt, m1_rvalid); end
        @(negedge clk);
        s_rvalid = 0;
        #1;
        checks++; if (s_req !== 1'b1 || m1_gnt !== 1'b1) begin errors++; $display("FAIL full_regrant: got req=%b gnt=%b exp 1 1", s_req, m1_gnt); end
        @(negedge clk);
        m1_req = 0; s_gnt = 0;
        for (int k = 0; k < 2; k++) begin
            s_rvalid = 1;
            #1;
            checks++; if (m1_rvalid !== 1'b1) begin errors++; $display("FAIL full_drain[%0d]: got %b exp 1", k, m1_rvalid); end
            @(negedge clk);
        end
        s_rvalid = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy: got %b exp 0", busy); end
    endtask

    task automatic test_mixed();
        do_reset();
        m1_req = 1; m1_we = 1; m1_wstrb = 4'hF; m1_wdata = 32'hCAFE_F00D; m1_addr = 32'h400; s_gnt = 1;
        #1;
        checks++; if (m1_gnt !== 1'b1 || s_we !== 1'b1 || s_wstrb !== 4'hF || s_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL mixed_store: got gnt=%b we=%b strb=%h wd=%h exp 1 1 f cafef00d", m1_gnt, s_we, s_wstrb, s_wdata); end
        @(negedge clk);
        m1_req = 0; m0_req = 1; m0_addr = 32'h84;
        #1;
        checks++; if (m0_gnt !== 1'b1 || s_we !== 1'b0 || s_wstrb !== 4'h0 || s_wdata !== 32'h0 || s_addr !== 32'h84) begin errors++; $display("FAIL mixed_fetch: got gnt=%b we=%b strb=%h wd=%h addr=%h exp 1 0 0 0 84", m0_gnt, s_we, s_wstrb, s_wdata, s_addr); end
        @(negedge clk);
        m0_req = 0; s_gnt = 0; s_rvalid = 1;
        #1;
        checks++; if ({m1_rvalid, m0_rvalid} !== 2'b10) begin errors++; $display("FAIL mixed_first_rv: got m1m0=%b exp 10", {m1_rvalid, m0_rvalid}); end
        @(negedge clk);
        #1;
        checks++; if ({m1_rvalid, m0_rvalid} !== 2'b01) begin errors++; $display("FAIL mixed_second_rv: got m1m0=%b exp 01", {m1_rvalid, m0_rvalid}); end
        @(negedge clk);
        s_rvalid = 0;
        #1;
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mixed_end: got busy=%b err=%b exp 0 0", busy, err); end
    endtask

    task automatic test_spurious();
        do_reset();
        s_rvalid = 1;
        #1;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00 || err !== 1'b0) begin errors++; $display("FAIL spurious_pre: got rv=%b err=%b exp 00 0", {m0_rvalid, m1_rvalid}, err); end
        @(negedge clk);
        s_rvalid = 0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL spurious_err: got %b exp 1", err); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL spurious_sticky: got err=%b busy=%b exp 1 0", err, busy); end
        do_reset();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL spurious_clear: got %b exp 0", err); end
    endtask

    task automatic test_reset_mid();
        bit exp_seq[6] = '{1, 1, 1, 1, 0, 1};
        do_reset();
        m0_req = 1; m1_req = 1; s_gnt = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if (busy !== 1'b0 || s_req !== 1'b0 || {m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL midreset_force: got busy=%b req=%b gnt=%b exp 0 0 00", busy, s_req, {m0_gnt, m1_gnt}); end
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        rst = 1;
        s_rvalid = 1;
        #1;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL midreset_stale_rv: got %b exp 00", {m0_rvalid, m1_rvalid}); end
        @(negedge clk);
        s_rvalid = 0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL midreset_stale_err: got %b exp 1", err); end
        m0_req = 1; m1_req = 1;
        for (int k = 0; k < 6; k++) begin
            s_rvalid = (k > 0);
            #1;
            checks++; if (m1_gnt !== exp_seq[k] || m0_gnt !== !exp_seq[k]) begin errors++; $display("FAIL midreset_gnt[%0d]: got m0=%b m1=%b exp m1=%b", k, m0_gnt, m1_gnt, exp_seq[k]); end
            @(negedge clk);
        end
        m0_req = 0; m1_req = 0; s_rvalid = 1;
        @(negedge clk);
        s_rvalid = 0; s_gnt = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b exp 0", busy); end
    endtask

    task automatic test_random();
        bit              p0, p1;
        logic [AW-1:0]   a0, a1;
        logic            we1;
        logic [DW-1:0]   wd1;
        logic [DW/8-1:0] ws1;
        bit              e_sreq, e_sel1, e_g0, e_g1, e_pop, e_rv0, e_rv1;
        logic [AW-1:0]   e_addr;
        logic            e_we;
        logic [DW-1:0]   e_wd;
        logic [DW/8-1:0] e_ws;
        do_reset();
        p0 = 0; p1 = 0; a0 = '0; a1 = '0; we1 = 0; wd1 = '0; ws1 = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1; a0 = $urandom; end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1; we1 = 1'($urandom_range(0, 1)); a1 = $urandom; wd1 = $urandom; ws1 = 4'($urandom);
            end
            m0_req = p0; m0_addr = a0;
            m1_req = p1; m1_we = we1; m1_addr = a1; m1_wdata = wd1; m1_wstrb = ws1;
            s_gnt = ($urandom_range(0, 3) != 0);
            s_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata = $urandom;
            #1;
            e_sreq = (p0 || p1) && (q.size() < OUTSTANDING);
            e_sel1 = p1 && !(p0 && mstreak == MAX_STREAK);
            e_g0   = e_sreq && s_gnt && !e_sel1;
            e_g1   = e_sreq && s_gnt && e_sel1;
            e_pop  = s_rvalid && (q.size() > 0);
            e_rv0  = e_pop && (q[0] == 0);
            e_rv1  = e_pop && (q[0] == 1);
            checks++; if (s_req !== e_sreq) begin errors++; $display("FAIL rand_s_req[%0d]: got %b exp %b", n, s_req, e_sreq); end
            checks++; if ({m0_gnt, m1_gnt} !== {e_g0, e_g1}) begin errors++; $display("FAIL rand_gnt[%0d]: got %b exp %b", n, {m0_gnt, m1_gnt}, {e_g0, e_g1}); end
            checks++; if ({m0_rvalid, m1_rvalid} !== {e_rv0, e_rv1}) begin errors++; $display("FAIL rand_rvalid[%0d]: got %b exp %b", n, {m0_rvalid, m1_rvalid}, {e_rv0, e_rv1}); end
            checks++; if (busy !== (q.size() > 0)) begin errors++; $display("FAIL rand_busy[%0d]: got %b exp %b", n, busy, q.size() > 0); end
            checks++; if (m0_rdata !== s_rdata || m1_rdata !== s_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h %h exp %h", n, m0_rdata, m1_rdata, s_rdata); end
            if (e_sreq) begin
                e_addr = e_sel1 ? a1 : a0;
                e_we   = e_sel1 && we1;
                e_wd   = e_sel1 ? wd1 : '0;
                e_ws   = e_sel1 ? ws1 : '0;
                checks++; if ({s_addr, s_we, s_wdata, s_wstrb} !== {e_addr, e_we, e_wd, e_ws}) begin errors++; $display("FAIL rand_payload[%0d]: got %h %b %h %h exp %h %b %h %h", n, s_addr, s_we, s_wdata, s_wstrb, e_addr, e_we, e_wd, e_ws); end
            end
            if (e_pop) void'(q.pop_front());
            if (e_g0 || e_g1) begin
                q.push_back(e_sel1 ? 1 : 0);
                if (e_sel1 && p0) mstreak = (mstreak < MAX_STREAK) ? mstreak + 1 : MAX_STREAK;
                else mstreak = 0;
            end
            if (e_g0) p0 = 0;
            if (e_g1) p1 = 0;
            @(negedge clk);
        end
        idle_inputs();
        for (int k = 0; k < OUTSTANDING && q.size() > 0; k++) begin
            s_rvalid = 1;
            #1;
            checks++; if (m1_rvalid !== (q[0] == 1) || m0_rvalid !== (q[0] == 0)) begin errors++; $display("FAIL rand_drain[%0d]: got m0=%b m1=%b exp owner %0d", k, m0_rvalid, m1_rvalid, q[0]); end
            void'(q.pop_front());
            @(negedge clk);
        end
        s_rvalid = 0;
        #1;
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rand_end: got busy=%b err=%b exp 0 0", busy, err); end
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        mstreak = 0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_full();
        test_mixed();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
